// File: rtl/imem_loader_if.sv
// rtl/imem_loader_if.sv - byte stream in and instruction-memory write port of the loader
interface imem_loader_if #(
  parameter int ADDR_W = 6
);
  logic [7:0]        in_data;
  logic              in_valid;
  logic              in_ready;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata;

  modport master (
    output in_data, in_valid,
    input  in_ready, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - packs a length/data/checksum byte stream into instruction words
// and writes them from address 0, holding the CPU in reset until a good load completes.
module imem_loader #(
  parameter int ADDR_W = 6,
  parameter int DATA_W = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  imem_loader_if.slave    bus,
  output logic            cpu_hold,
  output logic            busy,
  output logic            done,
  output logic            err
);
  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_LEN  = 3'd1;
  localparam logic [2:0] S_DATA = 3'd2;
  localparam logic [2:0] S_CSUM = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;
  localparam logic [2:0] S_ERR  = 3'd5;

  localparam logic [1:0]    LAST_BYTE  = 2'(DATA_W / 8 - 1);
  localparam logic [ADDR_W:0] FULL_DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] ONE_WORD   = {{ADDR_W{1'b0}}, 1'b1};

  logic [2:0]        state;
  logic [1:0]        byte_cnt;
  // One bit wider than the address so a full-depth load can count to 2**ADDR_W.
  logic [ADDR_W:0]   word_idx;
  logic [ADDR_W:0]   n_words;
  logic [ADDR_W:0]   word_nxt;
  logic [7:0]        csum;
  logic [DATA_W-9:0] shift;
  logic              accept;

  assign accept   = bus.in_valid && bus.in_ready;
  assign word_nxt = word_idx + ONE_WORD;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      bus.in_ready  <= 1'b0;
      bus.mem_we    <= 1'b0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
      cpu_hold      <= 1'b1;
      busy          <= 1'b0;
      done          <= 1'b0;
      err           <= 1'b0;
      byte_cnt      <= '0;
      word_idx      <= '0;
      n_words       <= '0;
      csum          <= '0;
      shift         <= '0;
    end else begin
      bus.mem_we <= 1'b0;
      case (state)
        S_IDLE, S_DONE, S_ERR: begin
          if (start) begin
            state        <= S_LEN;
            bus.in_ready <= 1'b1;
            busy         <= 1'b1;
            cpu_hold     <= 1'b1;
            done         <= 1'b0;
            err          <= 1'b0;
            csum         <= '0;
            word_idx     <= '0;
            byte_cnt     <= '0;
          end
        end
        S_LEN: begin
          if (accept) begin
            n_words <= (bus.in_data[ADDR_W-1:0] == '0) ? FULL_DEPTH
                                                       : {1'b0, bus.in_data[ADDR_W-1:0]};
            state   <= S_DATA;
          end
        end
        S_DATA: begin
          if (accept) begin
            csum <= csum ^ bus.in_data;
            if (byte_cnt == LAST_BYTE) begin
              bus.mem_we    <= 1'b1;
              bus.mem_wdata <= {shift, bus.in_data};
              bus.mem_addr  <= word_idx[ADDR_W-1:0];
              word_idx      <= word_nxt;
              byte_cnt      <= '0;
              if (word_nxt == n_words) state <= S_CSUM;
            end else begin
              shift    <= {shift[DATA_W-17:0], bus.in_data};
              byte_cnt <= byte_cnt + 2'd1;
            end
          end
        end
        S_CSUM: begin
          if (accept) begin
            bus.in_ready <= 1'b0;
            busy         <= 1'b0;
            if (bus.in_data == csum) begin
              done     <= 1'b1;
              cpu_hold <= 1'b0;
              state    <= S_DONE;
            end else begin
              err   <= 1'b1;
              state <= S_ERR;
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_imem_loader.sv
// tb/tb_imem_loader.sv - randomized self-checking bench for imem_loader
module tb_imem_loader;
  localparam int ADDR_W = 6;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cpu_hold, busy, done, err;
  int   checks = 0;
  int   failures = 0;

  logic [ADDR_W-1:0] cap_addr[$];
  logic [31:0]       cap_data[$];
  logic [31:0]       exp_words[$];

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DATA_W(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .bus      (bus),
    .cpu_hold (cpu_hold),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.mem_we === 1'b1) begin
      cap_addr.push_back(bus.mem_addr);
      cap_data.push_back(bus.mem_wdata);
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [7:0] model_csum();
    logic [7:0] c = 8'h00;
    foreach (exp_words[k]) c = c ^ exp_words[k][31:24] ^ exp_words[k][23:16]
                                 ^ exp_words[k][15:8] ^ exp_words[k][7:0];
    return c;
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gapped);
    if (gapped) begin
      int g = $urandom_range(0, 3);
      for (int i = 0; i < g; i++) begin
        bus.in_valid = 1'b0;
        bus.in_data  = 8'($urandom);
        start        = 1'($urandom_range(0, 1));
        @(negedge clk);
      end
    end
    start        = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    checks++;
    if (bus.in_ready !== 1'b1) begin
      failures++;
      $display("FAIL in_ready_in_session: got %b need 1", bus.in_ready);
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_session(input logic [7:0] len_b, input logic [7:0] cs, input bit gapped);
    cap_addr.delete();
    cap_data.delete();
    do_start();
    send_byte(len_b, gapped);
    foreach (exp_words[k])
      for (int j = 3; j >= 0; j--) send_byte(exp_words[k][8*j +: 8], gapped);
    send_byte(cs, gapped);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = 8'hA5;
    repeat (2) @(negedge clk);
    checks++;
    if ({cpu_hold, bus.in_ready, bus.mem_we, done, err, busy} !== 6'b100000) begin
      failures++;
      $display("FAIL reset_flags: got hold/rdy/we/done/err/busy=%b need 100000",
               {cpu_hold, bus.in_ready, bus.mem_we, done, err, busy});
    end
    checks++;
    if (bus.mem_addr !== '0 || bus.mem_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem: got addr=%h data=%h need 0/0", bus.mem_addr, bus.mem_wdata);
    end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (bus.in_ready !== 1'b0 || cap_data.size() != 0) begin
      failures++;
      $display("FAIL idle_ignores_valid: got in_ready=%b writes=%0d need 0/0",
               bus.in_ready, cap_data.size());
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic test_good_load();
    exp_words = '{32'h20010005, 32'h00221820};
    run_session(8'h02, 8'h3E, 1'b0);
    checks++;
    if (cap_data.size() != 2) begin
      failures++;
      $display("FAIL good_write_count: got %0d need 2", cap_data.size());
    end
    foreach (cap_data[k]) begin
      checks++;
      if (cap_addr[k] !== ADDR_W'(k) || cap_data[k] !== exp_words[k]) begin
        failures++;
        $display("FAIL good_write[%0d]: got %h:%h need %h:%h", k, cap_addr[k], cap_data[k], k, exp_words[k]);
      end
    end
    checks++;
    if ({done, err, cpu_hold, bus.in_ready, busy} !== 5'b10000) begin
      failures++;
      $display("FAIL good_status: got done/err/hold/rdy/busy=%b need 10000",
               {done, err, cpu_hold, bus.in_ready, busy});
    end
  endtask

  task automatic test_bad_csum();
    exp_words = '{32'h20010005, 32'h00221820};
    run_session(8'h02, 8'h3F, 1'b0);
    checks++;
    if (cap_data.size() != 2 || cap_data[0] !== 32'h20010005 || cap_data[1] !== 32'h00221820) begin
      failures++;
      $display("FAIL bad_writes: got count=%0d need 2 words intact", cap_data.size());
    end
    checks++;
    if ({done, err, cpu_hold, busy} !== 4'b0110) begin
      failures++;
      $display("FAIL bad_status: got done/err/hold/busy=%b need 0110", {done, err, cpu_hold, busy});
    end
    do_start();
    checks++;
    if ({done, err, cpu_hold, busy, bus.in_ready} !== 5'b00111) begin
      failures++;
      $display("FAIL restart_after_err: got done/err/hold/busy/rdy=%b need 00111",
               {done, err, cpu_hold, busy, bus.in_ready});
    end
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_gapped_random();
    for (int it = 0; it < 8; it++) begin
      int   n   = $urandom_range(1, 12);
      bit   bad = (it % 2) == 1;
      logic [7:0] len_b = 8'(($urandom_range(0, 3) << ADDR_W) | n);
      logic [7:0] cs;
      exp_words.delete();
      for (int k = 0; k < n; k++) exp_words.push_back($urandom);
      cs = model_csum() ^ (bad ? 8'($urandom_range(1, 255)) : 8'h00);
      run_session(len_b, cs, 1'b1);
      checks++;
      if (cap_data.size() != n) begin
        failures++;
        $display("FAIL rand_write_count it=%0d: got %0d need %0d", it, cap_data.size(), n);
      end
      foreach (cap_data[k]) begin
        checks++;
        if (k >= n || cap_addr[k] !== ADDR_W'(k) || cap_data[k] !== exp_words[k]) begin
          failures++;
          $display("FAIL rand_write it=%0d k=%0d: got %h:%h", it, k, cap_addr[k], cap_data[k]);
        end
      end
      checks++;
      if ({done, err, cpu_hold, busy} !== {!bad, bad, bad, 1'b0}) begin
        failures++;
        $display("FAIL rand_status it=%0d: got done/err/hold/busy=%b need %b", it,
                 {done, err, cpu_hold, busy}, {!bad, bad, bad, 1'b0});
      end
    end
  endtask

  task automatic test_full_depth();
    exp_words.delete();
    for (int k = 0; k < 64; k++) exp_words.push_back({4{8'(k)}});
    run_session(8'h00, 8'h00, 1'b0);
    checks++;
    if (cap_data.size() != 64) begin
      failures++;
      $display("FAIL full_write_count: got %0d need 64", cap_data.size());
    end
    foreach (cap_data[k]) begin
      checks++;
      if (k >= 64 || cap_addr[k] !== ADDR_W'(k) || cap_data[k][7:0] !== 8'(k)) begin
        failures++;
        $display("FAIL full_write k=%0d: got %h:%h", k, cap_addr[k], cap_data[k]);
      end
    end
    checks++;
    if ({done, err, cpu_hold} !== 3'b100) begin
      failures++;
      $display("FAIL full_status: got done/err/hold=%b need 100", {done, err, cpu_hold});
    end
  endtask

  task automatic test_reset_mid();
    logic [31:0] w0 = $urandom;
    cap_addr.delete();
    cap_data.delete();
    do_start();
    send_byte(8'h04, 1'b0);
    for (int j = 3; j >= 0; j--) send_byte(w0[8*j +: 8], 1'b0);
    repeat (2) send_byte(8'($urandom), 1'b0);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    checks++;
    if (cap_data.size() != 1 || cap_addr[0] !== '0 || cap_data[0] !== w0) begin
      failures++;
      $display("FAIL midreset_writes: got count=%0d need 1 word %h at 0", cap_data.size(), w0);
    end
    checks++;
    if ({cpu_hold, busy, bus.in_ready, done, err} !== 5'b10000) begin
      failures++;
      $display("FAIL midreset_status: got hold/busy/rdy/done/err=%b need 10000",
               {cpu_hold, busy, bus.in_ready, done, err});
    end
    bus.in_valid = 1'b1;
    repeat (6) @(negedge clk);
    bus.in_valid = 1'b0;
    checks++;
    if (cap_data.size() != 1 || bus.in_ready !== 1'b0) begin
      failures++;
      $display("FAIL midreset_quiet: got writes=%0d rdy=%b need 1/0", cap_data.size(), bus.in_ready);
    end
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;
    @(negedge clk);
    test_reset();
    test_good_load();
    test_bad_csum();
    test_gapped_random();
    test_full_depth();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
Writer side of the instruction-memory interface. It receives a byte stream over a valid/ready handshake, packs the bytes into 32-bit instruction words, and writes them sequentially into instruction memory starting at address 0. While a load is in progress or has failed, it holds the CPU in reset through cpu_hold. cpu_hold is ANDed into the PC/regfile reset path at top level.

Parameters:
ADDR_W, 6, instruction-memory word-address width (depth = 2**ADDR_W = 64 words); legal range 1..8.
DATA_W, 32, instruction word width; fixed at 4 bytes, no other value is supported.

Ports:
clk  input  1  rising-edge clock.
rst  input  1  synchronous reset, active-low (sampled on the clk rising edge when 0).
start  input  1  one-cycle request to begin a load session.
in_data  input  8  stream byte.
in_valid  input  1  in_data is valid.
in_ready  output  1  loader accepts a byte this cycle.
mem_we  output  1  instruction-memory write enable, one cycle per word.
mem_addr  output  ADDR_W  word address for the write.
mem_wdata  output  32  instruction word to write.
cpu_hold  output  1  1 = CPU held in reset.
busy  output  1  a session is in progress (states LEN, DATA, CSUM).
done  output  1  the last session completed with a good checksum.
err  output  1  the last session failed its checksum.

Behaviour:
- A byte is accepted on a clk edge where in_valid && in_ready. All outputs are registered.
- Reset (rst=0 at an edge):
  - state=IDLE.
  - in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0.
  - cpu_hold=1, busy=0, done=0, err=0.
  - Byte counter, word counter and checksum cleared.
- Reset mid-session aborts the session. Words already written stay in memory, and the loader returns to IDLE with cpu_hold=1.
- States:
  - IDLE: in_ready=0. start -> LEN; clear the checksum, word address and done/err.
  - LEN: in_ready=1. Accepted byte sets the word count N = byte[ADDR_W-1:0]; 0 means 2**ADDR_W. Upper bits are ignored. -> DATA.
  - DATA: in_ready=1.
    - Bytes are packed big-endian: the first byte of each word goes to [31:24], the fourth to [7:0].
    - Every data byte is XORed into an 8-bit checksum.
    - On acceptance of the 4th byte, the next cycle has mem_we=1, mem_wdata=the packed word, mem_addr=the current word index. The word index then increments.
    - After word N-1 has been packed -> CSUM.
  - CSUM: in_ready=1. The accepted byte is compared with the checksum. The length byte and the checksum byte are excluded from the XOR.
    - Match -> DONE, done=1, cpu_hold=0.
    - Mismatch -> ERR, err=1, cpu_hold stays 1.
  - DONE and ERR: in_ready=0. start -> LEN; done/err cleared, cpu_hold=1.
- cpu_hold goes to 1 on the edge that accepts start and stays 1 until DONE is entered.
- start is ignored in LEN, DATA and CSUM.
- in_valid is ignored when in_ready=0.
- Bytes may arrive back-to-back (one per cycle) or with any number of gap cycles. Throughput is 1 byte/cycle with no stalls.
- mem_we is high for exactly one cycle per word. mem_addr and mem_wdata are stable while mem_we=1.
- Word address wrap: N=2**ADDR_W writes addresses 0..63 with no overflow into 0. The counter is sized ADDR_W+1 internally.
- On a simultaneous start and rst=0, reset wins.
- busy=1 exactly in LEN, DATA and CSUM.

Test Plan:
- Reset: hold rst=0 for 2 cycles -> cpu_hold=1, in_ready=0, mem_we=0, done=0, err=0, busy=0.
- Good load, back-to-back: start; bytes 02, 20 01 00 05, 00 22 18 20, 3E -> mem_we pulses twice (addr 0 data 0x20010005, addr 1 data 0x00221820); then done=1, err=0, cpu_hold=0, in_ready=0.
- Bad checksum: same stream with final byte 3F -> both words written, err=1, done=0, cpu_hold=1. A new start then clears err and raises busy.
- Gapped stream: same good stream with in_valid toggling 1/0 randomly -> identical writes and done=1. No byte is double-counted while in_valid=0.
- Full depth: length byte 00, 256 data bytes where word k = {k,k,k,k}, then checksum 00 -> 64 writes at addr 0..63 with mem_wdata[7:0]=k, and done=1.
- Reset mid-session: start, length 04, 6 data bytes, then rst=0 for 1 cycle -> word 0 written, IDLE, cpu_hold=1, busy=0, in_ready=0, no further mem_we.
